// File: rtl/mult_div_unit_if.sv
// Issue/result bundle between the execute stage (master) and the multiply/divide unit (slave).
interface mult_div_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, input busy, hi, lo);
  modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// MIPS HI/LO multiply/divide unit: result lands MULT_CYCLES/DIV_CYCLES after issue, MTHI/MTLO next edge.
// No backpressure: start while busy is dropped, so hazard logic stalls on busy|start. MDU_MADD_EN enables MADD/MSUB.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic            clock,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MDU_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;
`endif

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_res_hi;
  logic [31:0] r_res_lo;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;
  logic        r_wr;
`ifdef MDU_MADD_EN
  logic        r_acc;
  logic        r_sub;
`endif

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_signed_div;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_den;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  assign w_prod_s = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
  assign w_prod_u = {32'd0, bus.a} * {32'd0, bus.b};

  // Divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 instead of overflowing.
  assign w_signed_div = (bus.op == OP_DIV);
  assign w_a_neg      = w_signed_div & bus.a[31];
  assign w_b_neg      = w_signed_div & bus.b[31];
  assign w_a_mag      = w_a_neg ? (32'd0 - bus.a) : bus.a;
  assign w_b_mag      = w_b_neg ? (32'd0 - bus.b) : bus.b;
  assign w_den        = (bus.b == 32'd0) ? 32'd1 : w_b_mag;
  assign w_q_mag      = w_a_mag / w_den;
  assign w_r_mag      = w_a_mag % w_den;
  assign w_quo        = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_rem        = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 5'd0;
      r_res_hi <= 32'd0;
      r_res_lo <= 32'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_busy   <= 1'b0;
      r_wr     <= 1'b0;
`ifdef MDU_MADD_EN
      r_acc    <= 1'b0;
      r_sub    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_MULT, OP_MULTU: begin
                {r_res_hi, r_res_lo} <= (bus.op == OP_MULT) ? w_prod_s : w_prod_u;
                r_cnt   <= 5'(MULT_CYCLES);
                r_wr    <= 1'b1;
                r_state <= S_BUSY;
                r_busy  <= 1'b1;
`ifdef MDU_MADD_EN
                r_acc   <= 1'b0;
`endif
              end
              OP_DIV, OP_DIVU: begin
                r_res_hi <= w_rem;
                r_res_lo <= w_quo;
                r_cnt    <= 5'(DIV_CYCLES);
                // Divide by zero still occupies the unit but leaves HI/LO alone.
                r_wr     <= (bus.b != 32'd0);
                r_state  <= S_BUSY;
                r_busy   <= 1'b1;
`ifdef MDU_MADD_EN
                r_acc    <= 1'b0;
`endif
              end
              OP_MTHI: r_hi <= bus.a;
              OP_MTLO: r_lo <= bus.a;
`ifdef MDU_MADD_EN
              OP_MADD, OP_MSUB: begin
                {r_res_hi, r_res_lo} <= w_prod_s;
                r_cnt   <= 5'(MULT_CYCLES);
                r_wr    <= 1'b1;
                r_acc   <= 1'b1;
                r_sub   <= (bus.op == OP_MSUB);
                r_state <= S_BUSY;
                r_busy  <= 1'b1;
              end
`endif
              default: ;
            endcase
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
`ifdef MDU_MADD_EN
            // Accumulate against HI/LO as they stand now; nothing else can write them while busy.
            if (r_acc) begin
              {r_hi, r_lo} <= r_sub ? ({r_hi, r_lo} - {r_res_hi, r_res_lo})
                                    : ({r_hi, r_lo} + {r_res_hi, r_res_lo});
            end else if (r_wr) begin
              r_hi <= r_res_hi;
              r_lo <= r_res_lo;
            end
`else
            if (r_wr) begin
              r_hi <= r_res_hi;
              r_lo <= r_res_lo;
            end
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed plus random stimulus for mult_div_unit, checked against an arithmetic HI/LO model.
module tb_mult_div_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] ref_hi;
  logic [31:0] ref_lo;

  mult_div_unit_if mdu ();

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (mdu)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural effect of one accepted op; returns the number of busy cycles it should produce.
  function automatic int model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    logic [63:0] acc;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = 64'(sa * sb); {ref_hi, ref_lo} = p; return MC; end
      3'd1: begin p = 64'(a) * 64'(b); {ref_hi, ref_lo} = p; return MC; end
      3'd2: begin
        if (b != 0) begin
          q = sa / sb; r = sa % sb;
          ref_lo = q[31:0]; ref_hi = r[31:0];
        end
        return DC;
      end
      3'd3: begin
        if (b != 0) begin ref_lo = a / b; ref_hi = a % b; end
        return DC;
      end
      3'd4: begin ref_hi = a; return 0; end
      3'd5: begin ref_lo = a; return 0; end
      default: begin
`ifdef MDU_MADD_EN
        p   = 64'(sa * sb);
        acc = {ref_hi, ref_lo};
        acc = (op == 3'd7) ? acc - p : acc + p;
        {ref_hi, ref_lo} = acc;
        return MC;
`else
        acc = 64'd0;
        p   = acc;
        return 0;
`endif
      end
    endcase
  endfunction

  // Issue one op at a negedge; optionally inject an ignored MULT 2*2 on busy cycle inj.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input int inj);
    logic [31:0] old_hi;
    int n, cnt;
    old_hi = ref_hi;
    n = model(op, a, b);
    mdu.start = 1'b1; mdu.op = op; mdu.a = a; mdu.b = b;
    @(negedge clock);
    mdu.start = 1'b0;
    cnt = 0;
    while (mdu.busy === 1'b1 && cnt < 100) begin
      cnt++;
      if (cnt == 1) check({tag, ":hold_hi"}, mdu.hi, old_hi);
      if (cnt == inj) begin
        mdu.start = 1'b1; mdu.op = 3'd0; mdu.a = 32'd2; mdu.b = 32'd2;
      end else begin
        mdu.start = 1'b0;
      end
      @(negedge clock);
    end
    mdu.start = 1'b0;
    check({tag, ":busy_len"}, 32'(cnt), 32'(n));
    check({tag, ":hi"}, mdu.hi, ref_hi);
    check({tag, ":lo"}, mdu.lo, ref_lo);
  endtask

  initial begin
    checks = 0; errors = 0;
    ref_hi = 0; ref_lo = 0;
    mdu.start = 1'b0; mdu.op = 3'd0; mdu.a = 32'd0; mdu.b = 32'd0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_busy", 32'(mdu.busy), 32'd0);
    check("rst_hi", mdu.hi, 32'd0);
    check("rst_lo", mdu.lo, 32'd0);
    reset = 1'b0;

    run_op(3'd0, 32'hFFFFFFFD, 32'd5, "mult_neg", 0);
    check("mult_neg_hi_const", mdu.hi, 32'hFFFFFFFF);
    check("mult_neg_lo_const", mdu.lo, 32'hFFFFFFF1);
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max", 0);
    check("multu_hi_const", mdu.hi, 32'hFFFFFFFE);
    run_op(3'd5, 32'h12345678, 32'd0, "mtlo", 0);
    check("mtlo_const", mdu.lo, 32'h12345678);
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, "div_neg", 0);
    check("div_neg_lo_const", mdu.lo, 32'hFFFFFFFD);
    run_op(3'd3, 32'd100, 32'd7, "divu", 0);
    check("divu_lo_const", mdu.lo, 32'd14);
    run_op(3'd2, 32'd55, 32'd0, "div_zero_inj", 4);
    @(negedge clock);
    check("inj_ignored_busy", 32'(mdu.busy), 32'd0);
    check("div_zero_hi_const", mdu.hi, 32'd2);
    check("div_zero_lo_const", mdu.lo, 32'd14);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, "div_ovf", 0);
    check("div_ovf_lo_const", mdu.lo, 32'h80000000);
    run_op(3'd1, 32'd3, 32'd0, "multu_zero", 0);

    // Reset on busy cycle 3 of MULT 6*7 must abort without a late write.
    mdu.start = 1'b1; mdu.op = 3'd0; mdu.a = 32'd6; mdu.b = 32'd7;
    @(negedge clock);
    mdu.start = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    ref_hi = 0; ref_lo = 0;
    check("abort_busy", 32'(mdu.busy), 32'd0);
    check("abort_hi", mdu.hi, 32'd0);
    check("abort_lo", mdu.lo, 32'd0);
    repeat (8) @(negedge clock);
    check("abort_late_lo", mdu.lo, 32'd0);

    // Reset wins over a simultaneous MTHI.
    run_op(3'd5, 32'hA5A5A5A5, 32'd0, "pre_prio", 0);
    reset = 1'b1; mdu.start = 1'b1; mdu.op = 3'd4; mdu.a = 32'd5;
    @(negedge clock);
    reset = 1'b0; mdu.start = 1'b0;
    ref_hi = 0; ref_lo = 0;
    check("prio_hi", mdu.hi, 32'd0);
    check("prio_lo", mdu.lo, 32'd0);

    run_op(3'd5, 32'hFFFFFFFF, 32'd0, "madd_mtlo", 0);
    run_op(3'd4, 32'd0, 32'd0, "madd_mthi", 0);
    run_op(3'd6, 32'd1, 32'd1, "madd", 0);
`ifdef MDU_MADD_EN
    check("madd_hi_const", mdu.hi, 32'd1);
    check("madd_lo_const", mdu.lo, 32'd0);
`else
    check("madd_off_hi_const", mdu.hi, 32'd0);
    check("madd_off_lo_const", mdu.lo, 32'hFFFFFFFF);
`endif
    run_op(3'd7, 32'hFFFFFFFE, 32'd3, "msub", 0);

    for (int i = 0; i < 150; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, "rand", 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS execute stage. Consumes the two register-file read operands (rs, rt) after forwarding, computes MULT/MULTU/DIV/DIVU over a fixed latency, and holds the results in HI/LO for later MFHI/MFLO reads. Exposes `busy` so the hazard logic can stall HI/LO-dependent instructions.

## Interface

Parameters:
- `MULT_CYCLES`, 5, busy cycles for MULT/MULTU (and MADD/MSUB variants); legal range 1..31.
- `DIV_CYCLES`, 10, busy cycles for DIV/DIVU; legal range 1..31.

Ports:
- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle issue strobe from the execute stage.
- `op`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB.
- `a`  in  32  rs operand (forwarded).
- `b`  in  32  rt operand (forwarded).
- `busy`  out  1  operation in flight.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation

- States: IDLE, BUSY. A 5-bit down-counter `cnt` tracks the remaining cycles.
- IDLE with `start`=1:
  - MULT/MULTU/DIV/DIVU: capture the full result into internal `res_hi`/`res_lo` from `a`/`b` in that cycle. Load `cnt` with the op latency and go to BUSY.
  - MTHI: `hi`<=`a`. MTLO: `lo`<=`a`. Either takes effect at that same edge, with no BUSY.
- BUSY: `cnt` decrements each cycle. In the cycle where `cnt`=1, `hi`/`lo` load `res_hi`/`res_lo` and the state returns to IDLE.
- `start` during BUSY is ignored entirely: operands, op and state are unchanged. The pipeline must stall instead.
- MULT: signed 32x32->64. `hi`=bits[63:32], `lo`=bits[31:0]. MULTU: unsigned.
- DIV: signed. Quotient is truncated toward zero into `lo`; remainder takes the sign of the dividend into `hi`.
  - 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0, with no error.
- DIVU: unsigned quotient into `lo`, remainder into `hi`.
- Divide by zero (`b`=0, DIV or DIVU): still takes DIV_CYCLES of BUSY. `hi` and `lo` are left unchanged at completion.
- Op 6/7 behaviour depends on `MDU_MADD_EN` (see Configuration).

## Timing

- Reset: `busy`=0, `hi`=0, `lo`=0, state IDLE, `cnt`=0, internal results=0.
- Reset during BUSY aborts the operation. The result is discarded and the reset values apply at the next edge.
- Reset has priority over `start` in the same cycle.
- `start` sampled in cycle t with a mult/div op (latency N):
  - `busy`=1 in cycles t+1..t+N.
  - New `hi`/`lo` are visible in cycle t+N+1, the same cycle `busy` falls.
- MTHI/MTLO in cycle t: new value visible in cycle t+1, and `busy` stays 0.
- Back-to-back issue: `start` in cycle t+N+1 is accepted, giving zero idle-gap throughput.
- `hi`/`lo` are registered outputs with no combinational path from the inputs. During BUSY they hold their old values.
- The hazard unit stalls on `busy`|`start` for any HI/LO consumer; that logic is outside this block.

## Configuration

- `MDU_MADD_EN` defined:
  - op 6 (MADD): `{hi,lo}` <= `{hi,lo}` + signed(a*b), modulo 2^64, using MULT_CYCLES.
  - op 7 (MSUB): `{hi,lo}` <= `{hi,lo}` - signed(a*b), modulo 2^64, using MULT_CYCLES.
  - The accumulate uses the `hi`/`lo` values present at completion. These equal the values at issue, because BUSY blocks other writers.
- Not defined: ops 6/7 are treated as no-ops. No BUSY is entered and `hi`/`lo` are unchanged. No accumulator adder is synthesized.

## Test plan

- MULT a=0xFFFFFFFD (-3), b=5 -> `busy` high exactly 5 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
- MULTU a=b=0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001 after 5 busy cycles. Then:
  - MTLO a=0x12345678 -> `lo`=0x12345678 next cycle, `busy` never asserts.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 10 busy cycles, `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU a=100, b=7 -> `lo`=14, `hi`=2. Then:
  - DIV with b=0 -> 10 busy cycles, `hi`=2, `lo`=14 unchanged.
  - A second `start` (MULT 2*2) issued on busy cycle 4 is ignored.
- MULT 6*7 with `reset` asserted on busy cycle 3 -> `busy`=0, `hi`=`lo`=0 next cycle, and no late write of 42 follows.
- With `MDU_MADD_EN`: MTLO 0xFFFFFFFF, MTHI 0, then MADD a=1, b=1 -> `hi`=1, `lo`=0.
  - Without the macro, the same sequence leaves `hi`=0, `lo`=0xFFFFFFFF, and `busy` never asserts.
